microseq_control: RTL
=====================

MICROSEQ_CONTROL -- requirements
Module: microseq_control

Interface
REQ-001 SHALL have parameter OPW, default 4: opcode width; values >4 SHALL decode as undefined when any bit above bit 3 is set.
REQ-002 SHALL have parameter STEPS, default 8: step-counter capacity; legal values are >=4; step width is SW=$clog2(STEPS).
REQ-003 SHALL have port CLK, input, 1: single clock; all state SHALL update on its rising edge only.
REQ-004 SHALL have port RST, input, 1: reset; synchronous, active-high.
REQ-005 SHALL have port command, input, OPW: opcode of the instruction register; sampled at every edge.
REQ-006 SHALL have port flags, input, 2: bit1 = carry, bit0 = zero, from the flags register; sampled at the T2 edge only.
REQ-007 SHALL have port stall, input, 1: freezes sequencing while high.
REQ-008 SHALL have port ctrl_wrd, output, 16: registered control word. Bit map: HLT=15, AI=14, AO=13, BI=12, MI=11, RR=10, RW=9, II=8, IO=7, CI=6, CO=5, CE=4, ALUOPTION=3, ALUO=2, DI=1, FL=0.
REQ-009 SHALL have port step, output, SW: current T-state.
REQ-010 SHALL have port instr_done, output, 1: high for exactly the cycle that carries an instruction's last step.
REQ-011 SHALL have port halted, output, 1: high once HLT has been issued.

Function
REQ-012 SHALL register all outputs; after each edge, ctrl_wrd SHALL equal microcode(step, command) for the new step value.
REQ-013 SHALL emit T0 = CO|MI and T1 = RR|II|CE for every opcode.
REQ-014 SHALL emit T2/T3 words as follows (instruction length L in parentheses):
  - 0001 LDA: IO|MI, RR|AI (4)
  - 0010 LDB: IO|MI, RR|BI (4)
  - 0011 PLUSTOA: ALUO|AI|FL (3)
  - 0100 PLUSTOB: ALUO|BI|FL (3)
  - 0101 SUBTOA: ALUOPTION|ALUO|AI|FL (3)
  - 0110 SUBTOB: ALUOPTION|ALUO|BI|FL (3)
  - 0111 ATORAM: IO|MI, AO|RW (4)
  - 1000 JUMP: IO|CI (3)
  - 1001 ATODIS: AO|DI (3)
  - 1010 POWEROFF: HLT (3)
  - 1011 JC: IO|CI if flags[1], else 0 (3)
  - 1100 JZ: IO|CI if flags[0], else 0 (3)
  - 0000 and 1101-1111: 0 (3)
REQ-015 SHALL advance step by 1 per unstalled edge; after step L-1, the next unstalled edge SHALL return step to 0 (T0). There are no dead cycles between instructions.
REQ-016 SHALL assert instr_done together with the step L-1 word.
REQ-017 SHALL, on an edge with stall=1 and halted=0, hold step and load ctrl_wrd=0 and instr_done=0. The first edge with stall=0 SHALL advance to step+1; no step is repeated or skipped.
REQ-018 SHALL, on the edge that emits HLT, set halted=1. While halted, step, ctrl_wrd=HLT and halted SHALL hold regardless of stall and command, until RST.
REQ-019 SHALL decode using the command value present at each edge. The control word for T2 and later uses command as latched by T1's II.
REQ-020 SHALL keep step at or below STEPS-1 at all times; if STEPS>4, steps 4..STEPS-1 are never reached.

Reset
REQ-021 SHALL, on an edge with RST=1, load ctrl_wrd=0, step=0, instr_done=0 and halted=0 into an internal pre-fetch state. RST overrides stall and halted.
REQ-022 SHALL emit T0 (CO|MI, step=0) on the first edge with RST=0.
REQ-023 SHALL abort any instruction in progress when RST is asserted mid-instruction, with no partial control words afterwards.

Verification
REQ-024 LDA: RST for 2 cycles, command=0001 -> words CO|MI, RR|II|CE, IO|MI, RR|AI with step 0,1,2,3; instr_done on step 3; next edge is CO|MI at step 0.
REQ-025 Back-to-back ADD then JZ: command=0011, then 1100 with flags=01 -> T2 words ALUO|AI|FL then IO|CI; each instruction is 3 cycles. Repeating with flags=00 gives a JZ T2 word of 0.
REQ-026 Stall: assert stall for 3 cycles after LDA T1 -> ctrl_wrd 0 for 3 cycles with step held at 1; then IO|MI (step 2), then RR|AI.
REQ-027 Halt: command=1010 -> HLT at step 2 with halted=1; for 10 further edges with arbitrary command and stall, outputs stay constant. RST then restarts at T0.
REQ-028 Reset mid-instruction: RST at ATORAM step 2 -> next output 0 with step 0; the first post-reset edge is CO|MI; no AO|RW is ever emitted.
REQ-029 Undefined opcode 1111 and OPW=6 opcode 010001 -> T2 word 0, L=3, instr_done on step 2.

Source files
------------

// File: rtl/microseq_control.sv
// rtl/microseq_control.sv - T-state microcode sequencer producing a registered 16-bit control word.
module microseq_control #(
    parameter int OPW   = 4,
    parameter int STEPS = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [OPW-1:0]           command,
    input  logic [1:0]               flags,
    input  logic                     stall,
    output logic [15:0]              ctrl_wrd,
    output logic [$clog2(STEPS)-1:0] step,
    output logic                     instr_done,
    output logic                     halted
);
    localparam int SW = $clog2(STEPS);

    localparam logic [15:0] C_HLT = 16'h8000, C_AI = 16'h4000, C_AO = 16'h2000, C_BI = 16'h1000;
    localparam logic [15:0] C_MI  = 16'h0800, C_RR = 16'h0400, C_RW = 16'h0200, C_II = 16'h0100;
    localparam logic [15:0] C_IO  = 16'h0080, C_CI = 16'h0040, C_CO = 16'h0020, C_CE = 16'h0010;
    localparam logic [15:0] C_SUB = 16'h0008, C_ALUO = 16'h0004, C_DI = 16'h0002, C_FL = 16'h0001;

    logic [15:0]   ctrl_q, ctrl_d;
    logic [SW-1:0] step_q, step_d;
    logic          done_q, done_d;
    logic          halted_q, halted_d;
    logic          prefetch_q, prefetch_d;

    logic          undef;
    logic [3:0]    op;
    logic [SW-1:0] last_step;
    logic [SW-1:0] next_step;

    function automatic logic [15:0] microcode(input logic [SW-1:0] s, input logic [3:0] opc,
                                              input logic [1:0] f);
        logic [15:0] w;
        w = 16'h0000;
        if (s == SW'(0)) begin
            w = C_CO | C_MI;
        end else if (s == SW'(1)) begin
            w = C_RR | C_II | C_CE;
        end else if (s == SW'(2)) begin
            case (opc)
                4'h1, 4'h2, 4'h7: w = C_IO | C_MI;
                4'h3: w = C_ALUO | C_AI | C_FL;
                4'h4: w = C_ALUO | C_BI | C_FL;
                4'h5: w = C_SUB | C_ALUO | C_AI | C_FL;
                4'h6: w = C_SUB | C_ALUO | C_BI | C_FL;
                4'h8: w = C_IO | C_CI;
                4'h9: w = C_AO | C_DI;
                4'hA: w = C_HLT;
                4'hB: w = f[1] ? (C_IO | C_CI) : 16'h0000;
                4'hC: w = f[0] ? (C_IO | C_CI) : 16'h0000;
                default: w = 16'h0000;
            endcase
        end else if (s == SW'(3)) begin
            case (opc)
                4'h1: w = C_RR | C_AI;
                4'h2: w = C_RR | C_BI;
                4'h7: w = C_AO | C_RW;
                default: w = 16'h0000;
            endcase
        end
        return w;
    endfunction

    always_comb begin
        ctrl_d     = ctrl_q;
        step_d     = step_q;
        done_d     = done_q;
        halted_d   = halted_q;
        prefetch_d = prefetch_q;
        next_step  = step_q;

        // Any opcode bit above the 4-bit field marks the instruction undefined.
        undef     = (command >> 4) != '0;
        op        = undef ? 4'h0 : command[3:0];
        last_step = (op == 4'h1 || op == 4'h2 || op == 4'h7) ? SW'(3) : SW'(2);

        if (!halted_q) begin
            if (stall) begin
                ctrl_d = 16'h0000;
                done_d = 1'b0;
            end else begin
                // >= also catches an opcode swap mid-instruction that shortens L.
                if (prefetch_q || step_q >= last_step) begin
                    next_step = '0;
                end else begin
                    next_step = step_q + SW'(1);
                end
                prefetch_d = 1'b0;
                step_d     = next_step;
                ctrl_d     = microcode(next_step, op, flags);
                done_d     = (next_step == last_step);
                halted_d   = ctrl_d[15];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_q     <= 16'h0000;
            step_q     <= '0;
            done_q     <= 1'b0;
            halted_q   <= 1'b0;
            prefetch_q <= 1'b1;
        end else begin
            ctrl_q     <= ctrl_d;
            step_q     <= step_d;
            done_q     <= done_d;
            halted_q   <= halted_d;
            prefetch_q <= prefetch_d;
        end
    end

    assign ctrl_wrd   = ctrl_q;
    assign step       = step_q;
    assign instr_done = done_q;
    assign halted     = halted_q;
endmodule
